// File: rtl/mem_wrapper_access_ctrl.sv
// mem_wrapper_access_ctrl
// Sequences one muxed memory request at a time onto the macro pins:
// IDLE -> SETUP (1 cycle) -> ACCESS (N cycles) -> DONE (o_valid pulse) -> RELEASE.
// Illegal opcodes skip the macro entirely and complete with o_err.
// Optional build macro: MEM_WRAPPER_ACCESS_CTRL_PARITY_EN adds write parity
// generation (o_mem_wpar) and read parity checking (i_mem_rpar).
module mem_wrapper_access_ctrl #(
    parameter int NBW_DATA     = 8,
    parameter int NBW_CNT      = 8,
    parameter int READ_CYCLES  = 2,
    parameter int PROG_CYCLES  = 10,
    parameter int ERASE_CYCLES = 50
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NBW_DATA-1:0] i_addr,
    input  logic [NBW_DATA-1:0] i_data,
    input  logic [3:0]          i_op,
    input  logic                i_region,
    input  logic                i_op_valid,
    output logic                o_valid,
    output logic [NBW_DATA-1:0] o_data,
    output logic                o_err,
    output logic                o_busy,
    output logic [NBW_DATA-1:0] o_mem_addr,
    output logic [NBW_DATA-1:0] o_mem_wdata,
    output logic                o_mem_ce,
    output logic                o_mem_we,
    output logic                o_mem_erase,
    output logic                o_mem_ifren,
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
    output logic                o_mem_wpar,
    input  logic                i_mem_rpar,
`endif
    input  logic [NBW_DATA-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] OP_READ  = 4'h1;
    localparam logic [3:0] OP_PROG  = 4'h2;
    localparam logic [3:0] OP_ERASE = 4'h3;

    // Counter preload is N-1 so that ACCESS lasts exactly N cycles.
    localparam logic [NBW_CNT-1:0] CNT_READ  = NBW_CNT'(READ_CYCLES - 1);
    localparam logic [NBW_CNT-1:0] CNT_PROG  = NBW_CNT'(PROG_CYCLES - 1);
    localparam logic [NBW_CNT-1:0] CNT_ERASE = NBW_CNT'(ERASE_CYCLES - 1);

    state_t              r_state;
    logic [NBW_CNT-1:0]  r_cnt;
    logic [NBW_DATA-1:0] r_addr;
    logic [NBW_DATA-1:0] r_data;
    logic [3:0]          r_op;
    logic                r_region;
    logic                r_valid;
    logic [NBW_DATA-1:0] r_rdata;
    logic                r_err;
    logic                r_busy;
    logic                r_ce;
    logic                r_we;
    logic                r_erase;
    logic                w_legal;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
    logic                r_wpar;
`endif

    assign w_legal = (i_op == OP_READ) || (i_op == OP_PROG) || (i_op == OP_ERASE);

    // Address, write data and region follow chip enable so they read 0 outside SETUP/ACCESS.
    assign o_mem_addr  = r_ce ? r_addr   : '0;
    assign o_mem_wdata = r_ce ? r_data   : '0;
    assign o_mem_ifren = r_ce ? r_region : 1'b0;
    assign o_mem_ce    = r_ce;
    assign o_mem_we    = r_we;
    assign o_mem_erase = r_erase;
    assign o_valid     = r_valid;
    assign o_data      = r_rdata;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
    assign o_mem_wpar  = r_wpar;
`endif

    // Access FSM with registered handshake and strobe outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_op     <= '0;
            r_region <= 1'b0;
            r_valid  <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_ce     <= 1'b0;
            r_we     <= 1'b0;
            r_erase  <= 1'b0;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
            r_wpar   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_op_valid) begin
                        r_addr   <= i_addr;
                        r_data   <= i_data;
                        r_op     <= i_op;
                        r_region <= i_region;
                        r_rdata  <= '0;
                        r_busy   <= 1'b1;
                        if (w_legal) begin
                            r_err   <= 1'b0;
                            r_ce    <= 1'b1;
                            r_state <= S_SETUP;
                        end else begin
                            // Illegal op completes immediately, macro untouched.
                            r_err   <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SETUP: begin
                    case (r_op)
                        OP_PROG:  r_cnt <= CNT_PROG;
                        OP_ERASE: r_cnt <= CNT_ERASE;
                        default:  r_cnt <= CNT_READ;
                    endcase
                    r_we    <= (r_op == OP_PROG);
                    r_erase <= (r_op == OP_ERASE);
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
                    r_wpar  <= (r_op == OP_PROG) ? ^r_data : 1'b0;
`endif
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_op == OP_READ) begin
                            r_rdata <= i_mem_rdata;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
                            r_err   <= (^i_mem_rdata) != i_mem_rpar;
`endif
                        end
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_erase <= 1'b0;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
                        r_wpar  <= 1'b0;
`endif
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - NBW_CNT'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Four-phase: wait for the requester to drop its level.
                    if (!i_op_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wrapper_access_ctrl.sv
// Scoreboard bench for mem_wrapper_access_ctrl: stimulus pushes expected
// completions, a forked monitor pops and compares on every o_valid.
module tb_mem_wrapper_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_addr, i_data, i_mem_rdata;
    logic [3:0] i_op;
    logic       i_region, i_op_valid;
    logic       o_valid, o_err, o_busy, o_mem_ce, o_mem_we, o_mem_erase, o_mem_ifren;
    logic [7:0] o_data, o_mem_addr, o_mem_wdata;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
    logic       o_mem_wpar, i_mem_rpar, par_flip, wpar_seen;
    always_comb i_mem_rpar = (^i_mem_rdata) ^ par_flip;
`endif

    mem_wrapper_access_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_addr(i_addr), .i_data(i_data), .i_op(i_op), .i_region(i_region),
        .i_op_valid(i_op_valid),
        .o_valid(o_valid), .o_data(o_data), .o_err(o_err), .o_busy(o_busy),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_ce(o_mem_ce),
        .o_mem_we(o_mem_we), .o_mem_erase(o_mem_erase), .o_mem_ifren(o_mem_ifren),
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
        .o_mem_wpar(o_mem_wpar), .i_mem_rpar(i_mem_rpar),
`endif
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         at;
    } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0;
    int ce_cnt, we_cnt, er_cnt, ovl;
    logic [7:0] addr_seen, wd_seen;
    logic       ifren_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        ce_cnt = 0; we_cnt = 0; er_cnt = 0; ovl = 0;
        addr_seen = 8'h00; wd_seen = 8'h00; ifren_seen = 1'b0;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
        wpar_seen = 1'b0;
`endif
    endtask

    // Issue one request, scramble inputs after accept, optionally hold the level past o_valid.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic rg, input logic [7:0] exp_d, input logic exp_e,
                         input int lat, input int hold);
        int n;
        int bl;
        exp_t e;
        @(negedge clk);
        clr_counts();
        i_op = op; i_addr = a; i_data = d; i_region = rg; i_op_valid = 1'b1;
        e.d = exp_d; e.e = exp_e; e.at = cyc + lat;
        q.push_back(e);
        @(negedge clk);
        if (lat > 1) chk("clear_on_accept", {23'd0, o_err, o_data}, 32'd0);
        i_addr = ~a; i_data = ~d; i_op = 4'hF; i_region = ~rg;
        n = 0;
        while (!o_valid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("valid_timeout", {31'd0, o_valid}, 32'd1);
        bl = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!o_busy) bl++;
        end
        if (hold > 0) chk("busy_in_release", bl, 0);
        i_op_valid = 1'b0;
        n = 0;
        while (o_busy && n < 10) begin @(negedge clk); n++; end
        chk("release_to_idle", n, (hold > 0) ? 1 : 2);
    endtask

    initial begin
        int n;
        rst = 1'b1; i_addr = '0; i_data = '0; i_op = '0; i_region = 1'b0;
        i_op_valid = 1'b0; i_mem_rdata = 8'h00;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
        par_flip = 1'b0;
`endif
        clr_counts();

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (o_mem_ce) begin
                        ce_cnt++; addr_seen = o_mem_addr; ifren_seen = o_mem_ifren;
                    end
                    if (o_mem_we) begin
                        we_cnt++; wd_seen = o_mem_wdata;
`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
                        wpar_seen = o_mem_wpar;
`endif
                    end
                    if (o_mem_erase) er_cnt++;
                    if ((o_mem_we && o_mem_erase) || ((o_mem_we || o_mem_erase) && !o_mem_ce)) ovl++;
                    if (o_valid) begin
                        if (q.size() == 0) chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
                        else begin
                            exp_t e;
                            e = q.pop_front();
                            chk("o_data", {24'd0, o_data}, {24'd0, e.d});
                            chk("o_err", {31'd0, o_err}, {31'd0, e.e});
                            chk("latency", cyc, e.at);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid_busy_err", {29'd0, o_valid, o_busy, o_err}, 32'd0);
        chk("rst_data", {24'd0, o_data}, 32'd0);
        chk("rst_strobes", {28'd0, o_mem_ce, o_mem_we, o_mem_erase, o_mem_ifren}, 32'd0);
        chk("rst_addr_wdata", {16'd0, o_mem_addr, o_mem_wdata}, 32'd0);
        rst = 1'b0;

        // READ
        i_mem_rdata = 8'hA5;
        do_op(4'h1, 8'h3C, 8'h99, 1'b0, 8'hA5, 1'b0, 4, 0);
        chk("read_ce_cycles", ce_cnt, 3);
        chk("read_no_we_erase", we_cnt + er_cnt, 0);
        chk("read_addr", {24'd0, addr_seen}, 32'h3C);
        chk("read_ifren", {31'd0, ifren_seen}, 32'd0);

        // PROGRAM
        do_op(4'h2, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0, 12, 0);
        chk("prog_we_cycles", we_cnt, 10);
        chk("prog_ce_cycles", ce_cnt, 11);
        chk("prog_wdata", {24'd0, wd_seen}, 32'h5A);
        chk("prog_addr", {24'd0, addr_seen}, 32'h10);
        chk("prog_overlap", ovl, 0);

        // Illegal op
        do_op(4'h7, 8'h44, 8'h55, 1'b0, 8'h00, 1'b1, 1, 0);
        chk("illegal_no_activity", ce_cnt + we_cnt + er_cnt, 0);

        // Held level, info block, error cleared by this accept
        i_mem_rdata = 8'h3E;
        do_op(4'h1, 8'h77, 8'h00, 1'b1, 8'h3E, 1'b0, 4, 20);
        chk("held_ifren", {31'd0, ifren_seen}, 32'd1);
        chk("held_addr", {24'd0, addr_seen}, 32'h77);

        // ERASE
        do_op(4'h3, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 52, 0);
        chk("erase_cycles", er_cnt, 50);
        chk("erase_ce_cycles", ce_cnt, 51);
        chk("erase_overlap", ovl, 0);

        // Reset mid-ERASE at the 5th ACCESS cycle
        @(negedge clk);
        i_op = 4'h3; i_addr = 8'h30; i_op_valid = 1'b1;
        n = 0;
        while (!o_mem_erase && n < 20) begin @(negedge clk); n++; end
        chk("erase_started", {31'd0, o_mem_erase}, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1; i_op_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_erase_strobe", {30'd0, o_mem_erase, o_mem_ce}, 32'd0);
        chk("rst_mid_busy_valid", {30'd0, o_busy, o_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        i_mem_rdata = 8'hC3;
        do_op(4'h1, 8'h21, 8'h00, 1'b0, 8'hC3, 1'b0, 4, 0);

`ifdef MEM_WRAPPER_ACCESS_CTRL_PARITY_EN
        i_mem_rdata = 8'h01; par_flip = 1'b1;
        do_op(4'h1, 8'h05, 8'h00, 1'b0, 8'h01, 1'b1, 4, 0);
        par_flip = 1'b0;
        do_op(4'h2, 8'h06, 8'h03, 1'b0, 8'h00, 1'b0, 12, 0);
        chk("wpar_even", {31'd0, wpar_seen}, 32'd0);
        do_op(4'h2, 8'h07, 8'h01, 1'b0, 8'h00, 1'b0, 12, 0);
        chk("wpar_odd", {31'd0, wpar_seen}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wrapper_access_ctrl.md
Name: mem_wrapper_access_ctrl

Overview:
- Downstream stage of the memory-wrapper access mux: consumes the muxed request (addr/data/op/region/op_valid) and returns valid/data to it.
- Sequences each operation onto the memory macro pins with programmable setup/access timing, using an FSM and a wait counter.
- Four-phase handshake toward the mux; one request in flight at a time.

Parameters:
- NBW_DATA, 8, width of address, write data and read data
- NBW_CNT, 8, width of the access wait counter
- READ_CYCLES, 2, access cycles for READ (≥1, <2^NBW_CNT)
- PROG_CYCLES, 10, access cycles for PROGRAM (≥1)
- ERASE_CYCLES, 50, access cycles for ERASE (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high
- i_addr  in  NBW_DATA  request address
- i_data  in  NBW_DATA  request write data
- i_op  in  4  opcode: 4'h1 READ, 4'h2 PROGRAM, 4'h3 ERASE, others illegal
- i_region  in  1  main memory (0) or information block (1)
- i_op_valid  in  1  request level, held until o_valid is seen
- o_valid  out  1  one-cycle completion pulse
- o_data  out  NBW_DATA  read data; 0 for non-READ ops
- o_err  out  1  illegal op flag, valid with o_valid
- o_busy  out  1  high in every state except IDLE
- o_mem_addr  out  NBW_DATA  macro address
- o_mem_wdata  out  NBW_DATA  macro write data
- o_mem_ce  out  1  macro chip enable
- o_mem_we  out  1  program strobe
- o_mem_erase  out  1  erase strobe
- o_mem_ifren  out  1  information-block select
- i_mem_rdata  in  NBW_DATA  macro read data

Behaviour:
- Reset, synchronous active-high: state IDLE; counter 0. All outputs 0: o_valid, o_data, o_err, o_busy, all o_mem_*. A reset mid-operation drops every strobe at that edge and discards the request.
- States:
  - IDLE: on i_op_valid=1, capture addr, data, op and region into registers.
    - Legal op → SETUP.
    - Illegal op → DONE with o_err=1.
  - SETUP: 1 cycle.
    - o_mem_ce=1; o_mem_addr, o_mem_wdata and o_mem_ifren driven from the captured registers.
    - Counter loaded with N-1, where N is READ_CYCLES, PROG_CYCLES or ERASE_CYCLES per op → ACCESS.
  - ACCESS: N cycles.
    - o_mem_ce=1.
    - o_mem_we=1 for PROGRAM; o_mem_erase=1 for ERASE.
    - Counter decrements each cycle. At counter==0: for READ, register i_mem_rdata into o_data → DONE.
  - DONE: 1 cycle. o_valid=1; o_mem_* all 0 → RELEASE.
  - RELEASE: wait while i_op_valid=1; → IDLE when i_op_valid=0.
- Latency:
  - Legal op: o_valid is high exactly N+2 cycles after the accepting edge.
  - Illegal op: o_valid is high 1 cycle after the accepting edge.
  - Minimum back-to-back spacing: N+4 cycles.
- o_data and o_err hold their values until the next accept, then clear to 0 at that accept edge.
- Mid-operation changes to i_addr, i_data, i_op and i_region are ignored (captured copies are used).
- Deasserting i_op_valid before o_valid does not abort the operation.
- The strobes never overlap; o_mem_ce is 0 outside SETUP/ACCESS.

Optional Feature:
- Macro: MEM_WRAPPER_ACCESS_CTRL_PARITY_EN.
- When defined, two ports are added: o_mem_wpar (out, 1) and i_mem_rpar (in, 1).
  - PROGRAM drives o_mem_wpar = even parity (XOR) of the captured data during ACCESS.
  - READ compares i_mem_rpar against XOR of i_mem_rdata at counter==0; a mismatch sets o_err=1 together with o_valid, and o_data still returns the read value.
- When undefined, the extra ports are absent and o_err flags illegal ops only.

Test Plan:
- Reset mid-ERASE: assert i_rst at the 5th ACCESS cycle → next edge o_mem_erase=0, o_busy=0, no o_valid; a fresh READ afterwards completes normally.
- READ, READ_CYCLES=2: i_op=1, addr=8'h3C, i_mem_rdata=8'hA5 → o_mem_ce high for 3 cycles, o_valid at +4 with o_data=8'hA5, o_err=0.
- PROGRAM, PROG_CYCLES=10: addr=8'h10, data=8'h5A → o_mem_we high for exactly 10 cycles with o_mem_wdata=8'h5A, o_valid at +12, o_data=0.
- Illegal op 4'h7 → o_valid and o_err=1 at +1, no o_mem_* activity; o_err clears on the next accept.
- Held i_op_valid: keep valid high 20 cycles past o_valid → stays in RELEASE with o_busy=1 and no second op; drop valid → IDLE the next cycle. The region=1 request drives o_mem_ifren=1.
- Parity build: READ with i_mem_rdata=8'h01, i_mem_rpar=0 → o_err=1, o_data=8'h01; PROGRAM data=8'h03 → o_mem_wpar=0.
